// File: rtl/irq_pkg.sv
// Shared constants and types for the FPGC4 interrupt controller.
package irq_pkg;

    // Default number of interrupt sources: int1..int4 plus FSX ontile_v.
    localparam int NUM_IRQ_DEFAULT = 5;

    // Width of the presented source index.
    localparam int IRQ_ID_W = 3;

    // Source index assignment on irq_in.
    localparam int IRQ_INT1   = 0;
    localparam int IRQ_INT2   = 1;
    localparam int IRQ_INT3   = 2;
    localparam int IRQ_INT4   = 3;
    localparam int IRQ_ONTILE = 4;

    // Request arbiter states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/interrupt_controller_if.sv
// CPU-side interrupt handshake bundle.
//
// Handshake: the controller raises cpu_int (level) with cpu_int_id stable
// for as long as cpu_int stays high. The CPU answers with a one-cycle
// cpu_ack pulse, which retires exactly the presented request. cpu_int then
// drops for at least one cycle before any next request is raised. cpu_ack
// while cpu_int is low has no effect.
interface interrupt_controller_if;
    import irq_pkg::*;

    logic                cpu_int;
    logic [IRQ_ID_W-1:0] cpu_int_id;
    logic                cpu_ack;

    // Controller side: drives the request, receives the acknowledge.
    modport master (
        output cpu_int,
        output cpu_int_id,
        input  cpu_ack
    );

    // CPU side: receives the request, drives the acknowledge.
    modport slave (
        input  cpu_int,
        input  cpu_int_id,
        output cpu_ack
    );

endinterface

// File: rtl/irq_line_filter.sv
// One interrupt line: synchronizer, glitch counter and single-shot event flag.
module irq_line_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_CYCLES = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic irq_i,
    output logic fire_o
);

    localparam int              CNT_W   = $clog2(GLITCH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GLITCH_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   full_q;
    logic                   fire_q, fire_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Saturating count of consecutive synchronized-high samples; any low sample
    // clears it, which is also what re-arms the line for the next event.
    always_comb begin
        cnt_d = cnt_q;
        if (!sync_s) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Pulse only on the first cycle the counter sits at its ceiling.
        fire_d = (cnt_q == CNT_MAX) && !full_q;
    end

    // Synchronizer chain, counter, ceiling memory and fire flag.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
            fire_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
            cnt_q  <= cnt_d;
            full_q <= (cnt_q == CNT_MAX);
            fire_q <= fire_d;
        end
    end

    assign fire_o = fire_q;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: per-line filtering, pending latch and a single
// prioritized request to the CPU (lowest index wins).
module interrupt_controller
    import irq_pkg::*;
#(
    parameter int NUM_IRQ       = NUM_IRQ_DEFAULT,
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [NUM_IRQ-1:0]       irq_in,
    input  logic [NUM_IRQ-1:0]       irq_mask,
    input  logic [NUM_IRQ-1:0]       clear,
    output logic [NUM_IRQ-1:0]       pending,
    output arb_state_e               state_o,
    interrupt_controller_if.master   cpu
);

    logic [NUM_IRQ-1:0]  fire;
    logic [NUM_IRQ-1:0]  pending_q, pending_d;
    logic [NUM_IRQ-1:0]  avail;
    logic [NUM_IRQ-1:0]  ack_clr;
    logic [IRQ_ID_W-1:0] low_id;
    logic [IRQ_ID_W-1:0] id_q, id_d;
    logic                int_q, int_d;
    arb_state_e          state_q, state_d;

    // One filter per source line.
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
        irq_line_filter #(
            .SYNC_STAGES   (SYNC_STAGES),
            .GLITCH_CYCLES (GLITCH_CYCLES)
        ) u_filter (
            .clk    (clk),
            .nreset (nreset),
            .irq_i  (irq_in[gi]),
            .fire_o (fire[gi])
        );
    end

    // Lowest-index enabled pending source.
    always_comb begin
        avail  = pending_q & irq_mask;
        low_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (avail[i]) begin
                low_id = IRQ_ID_W'(i);
            end
        end
    end

    // Arbiter next state; the presented id is frozen for the whole REQ phase.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ack_clr = '0;
        case (state_q)
            IDLE: begin
                if (|avail) begin
                    id_d    = low_id;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (cpu.cpu_ack) begin
                    state_d = GAP;
                    for (int i = 0; i < NUM_IRQ; i++) begin
                        if (id_q == IRQ_ID_W'(i)) begin
                            ack_clr[i] = 1'b1;
                        end
                    end
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        int_d = (state_d == REQ);
    end

    // Pending update: a fresh accepted event beats any clear in the same cycle.
    always_comb begin
        pending_d = (pending_q & ~(clear | ack_clr)) | (fire & irq_mask);
    end

    // State, request and pending registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= IDLE;
            id_q      <= '0;
            int_q     <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            int_q     <= int_d;
            pending_q <= pending_d;
        end
    end

    assign cpu.cpu_int    = int_q;
    assign cpu.cpu_int_id = id_q;
    assign pending        = pending_q;
    assign state_o        = state_q;

endmodule
